sm4_tau_arbiter: RTL
====================

Name: sm4_tau_arbiter

Overview:
- Shares one registered SM4 tau unit among NUM_REQ requesters, typically key expansion (req 0) and the round function (req 1).
- The tau unit is four byte S-box lookups applied in parallel to a 32-bit word.
- The block arbitrates requests, pipelines them through the S-boxes and returns each result with the winner's id and tag.
- It sits between the SM4 key-schedule/round controllers and the S-box datapath.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 1, width of requester index; must equal max(1, clog2(NUM_REQ)).
- TAG_W, 4, opaque tag carried from request to response (e.g. round number).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; high on the cycle the request is taken.
- req_data  in  NUM_REQ*32  packed input words; requester i occupies bits [32i+31:32i].
- req_tag  in  NUM_REQ*TAG_W  packed tags.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_tag  out  TAG_W  tag echoed from the request.
- rsp_data  out  32  tau(req_data): byte k of output = Sbox(byte k of input), k=0..3.

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_data=0, all stage-valid flags 0. Round-robin pointer set so requester 0 has highest priority first.
- req_ready is combinational and driven low while rst_n=0.
- Pipeline has two stages:
  - S1 holds {id, tag, input word}.
  - S2 is the output register {id, tag, tau result}. Tau is computed combinationally from S1 and captured into S2.
- Advance rules:
  - S2 loads when S1 is valid and (S2 empty or rsp_ready).
  - S1 loads when the arbiter grants and (S1 empty or S1 advancing in the same cycle).
- Latency: request accepted in cycle N gives rsp_valid in cycle N+2 if there is no backpressure.
- Throughput: one result per cycle when rsp_ready is held high.
- Arbitration:
  - Round-robin among asserted req_valid, starting at the index after the last granted one.
  - Pointer updates only on an actual accept (grant and S1 can load).
  - At most one req_ready bit is high per cycle: req_ready[i] = grant[i] & s1_can_load. req_ready may depend on req_valid.
- Requester rules: keep req_valid/data/tag stable until accepted. Deasserting valid without an accept is allowed and drops the request (no side effect).
- Backpressure: rsp_valid/id/tag/data hold stable while rsp_valid=1 and rsp_ready=0. With both stages full and rsp_ready=0, every req_ready=0.
- Simultaneous events:
  - Pop of S2 and push from S1 in the same cycle is allowed.
  - Accept into S1 while S1 drains to S2 is allowed (full-rate flow).
- Only one requester valid: it is granted every cycle it is valid, regardless of the pointer.
- Reset mid-operation: in-flight data is discarded, no response is produced, and the pointer returns to its reset value.
- S-box table: standard SM4 table; Sbox(0x00)=0xd6, Sbox(0xff)=0x48.

Optional Feature:
- Macro SM4_TAU_ARB_FIXED_PRIO_EN.
- When defined: strict fixed priority, lowest index wins, so key expansion always pre-empts rounds. The pointer register is not instantiated.
- When undefined: round-robin as above. The port list is identical in both builds.

Decomposition:
- Shared package sm4_pkg holds:
  - SM4_WORD_W=32;
  - the tau word typedef;
  - the function packing/unpacking per-requester slices.
- One natural sub-module, sm4_tau: four byte S-box instances forming a purely combinational 32-bit tau. The arbiter and pipeline registers stay in sm4_tau_arbiter.

Test Plan:
- Single request: req 0 valid, data 0x01234567, tag 0x3, rsp_ready=1. Expect rsp_valid exactly 2 cycles after accept, rsp_data=0x90f473a2, rsp_id=0, rsp_tag=0x3.
- Edge words: data 0x00000000 gives 0xd6d6d6d6; 0xffffffff gives 0x48484848; 0xabab0000 gives 0xababd6d6.
- Contention: req 0 and req 1 held valid for 6 cycles. Round-robin build: grants alternate 0,1,0,1,0,1. Build with SM4_TAU_ARB_FIXED_PRIO_EN: all 6 grants go to 0 and req 1 is never ready.
- Backpressure: rsp_ready=0 with 3 back-to-back requests. Exactly 2 are accepted and the third sees req_ready=0. rsp outputs stay stable. Releasing rsp_ready drains 2 results in order, then the third is accepted.
- Full-rate streaming: 16 words from req 1 with rsp_ready=1. One result per cycle, in order, tags 0..15, no bubbles.
- Reset mid-flight: assert rst_n=0 with both stages full. rsp_valid drops immediately (async). After release, no stale response appears and the first grant goes to req 0 when both are valid.

Source files
------------

// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: word type, standard S-box table and per-requester
// word unpacking used by the tau arbiter.
package sm4_pkg;

  localparam int SM4_WORD_W  = 32;
  localparam int SM4_MAX_REQ = 8;

  typedef logic [SM4_WORD_W-1:0]             sm4_word_t;
  typedef logic [SM4_MAX_REQ*SM4_WORD_W-1:0] sm4_word_bus_t;

  // Standard SM4 S-box, one 16-entry row per 128-bit literal; entry 0 is leftmost.
  localparam logic [0:255][7:0] SM4_SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  // Extracts requester idx's word from a packed request bus.
  function automatic sm4_word_t word_slice(input sm4_word_bus_t bus, input logic [2:0] idx);
    return bus[idx*SM4_WORD_W +: SM4_WORD_W];
  endfunction

  // Places a word into requester idx's slot of an otherwise zero bus.
  function automatic sm4_word_bus_t word_place(input sm4_word_t w, input logic [2:0] idx);
    sm4_word_bus_t bus;
    bus = '0;
    bus[idx*SM4_WORD_W +: SM4_WORD_W] = w;
    return bus;
  endfunction

endpackage

// File: rtl/sm4_tau.sv
// Combinational SM4 tau: four parallel byte S-box lookups over a 32-bit word.
module sm4_tau
  import sm4_pkg::*;
(
  input  sm4_word_t word_i,
  output sm4_word_t word_o
);

  for (genvar k = 0; k < 4; k++) begin : g_sbox
    assign word_o[8*k +: 8] = SM4_SBOX[word_i[8*k +: 8]];
  end

endmodule

// File: rtl/sm4_tau_arbiter.sv
// Shares one registered SM4 tau unit among NUM_REQ requesters (S1 request reg,
// S2 result reg). Define SM4_TAU_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module sm4_tau_arbiter
  import sm4_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int TAG_W   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*SM4_WORD_W-1:0] req_data,
  input  logic [NUM_REQ*TAG_W-1:0]      req_tag,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [TAG_W-1:0]              rsp_tag,
  output sm4_word_t                     rsp_data
);

  logic             s1_valid_q, s1_valid_d;
  logic [ID_W-1:0]  s1_id_q,    s1_id_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
  sm4_word_t        s1_data_q,  s1_data_d;

  logic             s2_valid_q, s2_valid_d;
  logic [ID_W-1:0]  s2_id_q,    s2_id_d;
  logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;
  sm4_word_t        s2_data_q,  s2_data_d;

  logic             s2_load;
  logic             s1_can_load;
  logic             gnt_found;
  logic [ID_W-1:0]  gnt_id;
  logic             accept;
  sm4_word_t        sel_word;
  logic [TAG_W-1:0] sel_tag;
  sm4_word_t        tau_word;
  sm4_word_bus_t    data_bus;

  assign s2_load     = s1_valid_q & (~s2_valid_q | rsp_ready);
  assign s1_can_load = ~s1_valid_q | s2_load;
  assign accept      = gnt_found & s1_can_load & rst_n;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (gnt_id == ID_W'(i));
    end
  end

`ifdef SM4_TAU_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    // Scan downward so the lowest-index valid requester is the last writer.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(i);
      end
    end
  end
`else
  // ptr_q is the requester with highest priority this cycle.
  logic [ID_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int idx;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = int'(ptr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign data_bus = sm4_word_bus_t'(req_data);
  assign sel_word = word_slice(data_bus, 3'(gnt_id));
  assign sel_tag  = req_tag[int'(gnt_id)*TAG_W +: TAG_W];

  sm4_tau u_tau (
    .word_i (s1_data_q),
    .word_o (tau_word)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_tag_d   = s1_tag_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    s2_tag_d   = s2_tag_q;
    s2_data_d  = s2_data_q;

    if (s2_load) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b1;
      s2_id_d    = s1_id_q;
      s2_tag_d   = s1_tag_q;
      s2_data_d  = tau_word;
    end else if (rsp_ready) begin
      s2_valid_d = 1'b0;
    end

    // A fresh accept overrides the drain of S1 in the same cycle.
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_id_d    = gnt_id;
      s1_tag_d   = sel_tag;
      s1_data_d  = sel_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_tag_q   <= '0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_tag_q   <= '0;
      s2_data_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_tag_q   <= s1_tag_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_tag_q   <= s2_tag_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign rsp_valid = s2_valid_q;
  assign rsp_id    = s2_id_q;
  assign rsp_tag   = s2_tag_q;
  assign rsp_data  = s2_data_q;

endmodule
